// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALU operation classes,
// R-type funct codes and the multiplier sequencing states.
package mips_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULTU = 6'h19;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ex_state_t;

endpackage

// File: rtl/ex_stage_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle,
// WIDTH cycles in BUSY. product_o is valid while done_o is high.
module mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);
    import mips_pkg::*;

    localparam int CW = $clog2(WIDTH);

    ex_state_t             state_q;
    logic [CW-1:0]         count_q;
    logic [2*WIDTH-1:0]    mcand_q;
    logic [2*WIDTH-1:0]    acc_q;
    logic [2*WIDTH-1:0]    acc_d;
    logic [WIDTH-1:0]      mplier_q;

    // The final step's sum is exposed combinationally so the caller can
    // capture the full product on the same edge the FSM returns to IDLE.
    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    assign busy_o    = (state_q == BUSY);
    assign done_o    = busy_o && (count_q == CW'(WIDTH - 1));
    assign product_o = acc_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mcand_q  <= {{WIDTH{1'b0}}, a_i};
                        mplier_q <= b_i;
                        acc_q    <= '0;
                        count_q  <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 1'b1;
                    if (done_o) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU decode and compute, branch target, HI/LO with an
// iterative multu, stall back-pressure, and the EX/MEM pipeline register.
module ex_stage #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ctrl_regWrite_id_ex,
    input  logic              ctrl_memToReg_id_ex,
    input  logic              ctrl_branch_id_ex,
    input  logic              ctrl_memRead_id_ex,
    input  logic              ctrl_memWrite_id_ex,
    input  logic              ctrl_regDest_id_ex,
    input  logic              ctrl_aluSrc_id_ex,
    input  logic [1:0]        ctrl_aluOp_id_ex,
    input  logic [WIDTH-1:0]  supposed_next_address_id_ex,
    input  logic [WIDTH-1:0]  read_data_1_id_ex,
    input  logic [WIDTH-1:0]  read_data_2_id_ex,
    input  logic [WIDTH-1:0]  extended_branch_offset_id_ex,
    input  logic [RA_W-1:0]   rt_id_ex,
    input  logic [RA_W-1:0]   rd_id_ex,
    output logic              stall,
    output logic              ctrl_regWrite_ex_mem,
    output logic              ctrl_memToReg_ex_mem,
    output logic              ctrl_branch_ex_mem,
    output logic              ctrl_memRead_ex_mem,
    output logic              ctrl_memWrite_ex_mem,
    output logic              zero_ex_mem,
    output logic [WIDTH-1:0]  alu_result_ex_mem,
    output logic [WIDTH-1:0]  branch_target_ex_mem,
    output logic [WIDTH-1:0]  write_data_ex_mem,
    output logic [RA_W-1:0]   write_reg_ex_mem
);
    import mips_pkg::*;

    logic [5:0]               funct;
    logic                     is_multu;
    logic                     mul_busy;
    logic                     mul_done;
    logic [2*WIDTH-1:0]       mul_product;
    logic [WIDTH-1:0]         hi_q;
    logic [WIDTH-1:0]         lo_q;
    logic signed [WIDTH-1:0]  op_a;
    logic signed [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]         alu_d;
    logic                     pass_ctrl;

    assign funct    = extended_branch_offset_id_ex[5:0];
    assign is_multu = (ctrl_aluOp_id_ex == ALUOP_RTYPE) && (funct == FN_MULTU);
    assign op_a     = read_data_1_id_ex;
    assign op_b     = ctrl_aluSrc_id_ex ? extended_branch_offset_id_ex : read_data_2_id_ex;

    // Stall covers the IDLE detection cycle plus every BUSY cycle but the
    // last, so upstream releases the multu on the cycle the product lands.
    assign stall     = reset && ((is_multu && !mul_busy) || (mul_busy && !mul_done));
    assign pass_ctrl = !stall && !is_multu;

    mul_unit #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (is_multu),
        .a_i       (read_data_1_id_ex),
        .b_i       (read_data_2_id_ex),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        alu_d = '0;
        case (ctrl_aluOp_id_ex)
            ALUOP_SUB:   alu_d = op_a - op_b;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_d = op_a + op_b;
                    FN_SUB:  alu_d = op_a - op_b;
                    FN_AND:  alu_d = op_a & op_b;
                    FN_OR:   alu_d = op_a | op_b;
                    FN_SLT:  alu_d = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
                    FN_MFHI: alu_d = hi_q;
                    FN_MFLO: alu_d = lo_q;
                    default: alu_d = '0;
                endcase
            end
            default:     alu_d = op_a + op_b;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (mul_done) begin
            {hi_q, lo_q} <= mul_product;
        end
    end

    // EX/MEM boundary: control collapses to a bubble while stalled and for
    // the retiring multu; data is loaded unconditionally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_regWrite_ex_mem <= 1'b0;
            ctrl_memToReg_ex_mem <= 1'b0;
            ctrl_branch_ex_mem   <= 1'b0;
            ctrl_memRead_ex_mem  <= 1'b0;
            ctrl_memWrite_ex_mem <= 1'b0;
            zero_ex_mem          <= 1'b0;
            alu_result_ex_mem    <= '0;
            branch_target_ex_mem <= '0;
            write_data_ex_mem    <= '0;
            write_reg_ex_mem     <= '0;
        end else begin
            ctrl_regWrite_ex_mem <= pass_ctrl && ctrl_regWrite_id_ex;
            ctrl_memToReg_ex_mem <= !stall && ctrl_memToReg_id_ex;
            ctrl_branch_ex_mem   <= !stall && ctrl_branch_id_ex;
            ctrl_memRead_ex_mem  <= pass_ctrl && ctrl_memRead_id_ex;
            ctrl_memWrite_ex_mem <= pass_ctrl && ctrl_memWrite_id_ex;
            zero_ex_mem          <= (alu_d == '0);
            alu_result_ex_mem    <= alu_d;
            branch_target_ex_mem <= supposed_next_address_id_ex + (extended_branch_offset_id_ex << 2);
            write_data_ex_mem    <= read_data_2_id_ex;
            write_reg_ex_mem     <= ctrl_regDest_id_ex ? rd_id_ex : rt_id_ex;
        end
    end

endmodule
